fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- PC register and instruction-fetch stage that consumes NextPC from the next-PC logic and feeds decode.
- Holds the fetch PC and issues word fetches to instruction memory over a req/ack handshake with variable latency.
- Buffers up to 2 fetched instructions toward decode through a valid/ready interface.
- A taken branch (redirect) flushes the buffer and restarts fetch at the new PC.

Parameters:
RESET_PC, 64'h0, fetch PC loaded on reset
BUF_DEPTH, 2, fetch-buffer entries (fixed at 2; other values not supported)

Ports:
CLK  input  1  clock, all state on rising edge
resetl  input  1  asynchronous active-low reset
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  64  NextPC target from next-PC logic
imem_req  output  1  fetch request
imem_addr  output  64  fetch word address
imem_ack  input  1  memory returns data this cycle (legal only while imem_req=1)
imem_rdata  input  32  instruction word, valid with imem_ack
if_valid  output  1  buffer head valid to decode
if_instr  output  32  buffer head instruction
if_pc  output  64  PC of buffer head instruction
id_ready  input  1  decode accepts head this cycle

Behaviour:
Reset (resetl=0, asynchronous):
- fpc=RESET_PC; buffer empty (count=0); state=FETCH.
- imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0.

Handshakes:
- Memory: imem_req and imem_addr are registered, held stable until the ack cycle inclusive. A request is never retracted once asserted.
- Decode: a transfer occurs on if_valid & id_ready.
- if_instr and if_pc are stable while if_valid=1 and id_ready=0.

States:
- FETCH:
  - imem_req=1, imem_addr=fpc whenever slots_free>0, where slots_free = BUF_DEPTH - count, counting a pop in the same cycle.
  - On ack: push {fpc, imem_rdata}; fpc += 4 (64-bit wrap, 64'hFFFF_FFFF_FFFF_FFFC -> 0).
  - The next request may assert in the cycle after ack (no back-to-back in the ack cycle).
- STALL:
  - Entered when count==2 after a push. imem_req=0.
  - Returns to FETCH in the cycle after a pop.
- DROP:
  - Entered when a redirect arrives while a request is outstanding and not acked in that same cycle.
  - imem_req stays 1 with the old address until ack; the returned data is discarded (no push).
  - Then returns to FETCH with the new fpc.

Redirect (highest priority):
- Flush the buffer (count=0, if_valid=0 next cycle).
- fpc = {redirect_pc[63:2], 2'b00}; misaligned low bits are silently cleared.
- A concurrent ack in the same cycle is discarded.
- A concurrent pop is ignored (entry flushed anyway).
- Redirect during DROP: update fpc only, remain in DROP.
- Redirect during STALL: go to FETCH.

Latency and throughput:
- Ack in cycle N -> if_valid=1 with that instruction in cycle N+1.
- Redirect in cycle N -> imem_req with the new address in cycle N+1 if no request is outstanding.
- Max throughput is 1 instruction per 2 cycles with 1-cycle ack.

Buffer:
- In-order FIFO.
- Simultaneous push and pop at count=1: count stays 1, the head advances to the pushed entry.
- Push at count=2 cannot occur (no request issued).
- Pop at count=0 ignored.

Reset mid-operation:
- Immediately forces reset values.
- Any ack after reset deassertion for a pre-reset request is a protocol violation (not handled).

Test Plan:
- Reset, ack 1 cycle after each req, id_ready=1 -> addresses 0,4,8,C; if_pc sequence 0,4,8,C; if_instr equals supplied words.
- id_ready=0, acks for 0x0 and 0x4 -> count=2, imem_req drops to 0 with fpc=0x8. Raise id_ready -> if_pc 0x0 then 0x4; req to 0x8 the cycle after the first pop.
- Req to 0x10 outstanding, redirect_pc=0x40 one cycle later, ack after 3 cycles -> data for 0x10 never appears on if_*; next req addr=0x40; first if_pc=0x40.
- Redirect_pc=0x80 in the same cycle as ack for 0x14 -> 0x14 discarded, buffer flushed; next imem_addr=0x80.
- redirect_pc=0x23 -> imem_addr=0x20. Redirect to 64'hFFFF_FFFF_FFFF_FFFC, ack -> next addr 0x0.
- Assert resetl=0 mid-DROP with count=1 -> immediately if_valid=0, imem_req=0. After release, first req addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the fetch PC, issues word fetches over a req/ack handshake
// and queues up to two fetched instructions toward decode; redirects flush and restart.
module fetch_pc_unit #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        CLK,
   input  logic        resetl,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [63:0] if_pc,
   input  logic        id_ready
);

   localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

   typedef enum logic [1:0] {FETCH, STALL, DROP} stateT;

   stateT       state, stateNext;
   logic [63:0] fpc, fpcNext;
   logic        reqNext;
   logic [63:0] addrNext;
   logic [1:0]  count, countNext, countPop;
   logic        rdPtr, rdPtrNext, wrPtr, wrPtrNext;
   logic        ack, pop, push;
   logic [63:0] redirectTarget;
   logic [63:0] pcMem    [2];
   logic [31:0] instrMem [2];

   assign redirectTarget = redirect_pc & ~64'h3;
   assign ack            = imem_req & imem_ack;
   assign pop            = if_valid & id_ready & ~redirect_valid;
   assign countPop       = count - {1'b0, pop};

   assign if_valid = (count != 2'd0);
   assign if_instr = if_valid ? instrMem[rdPtr] : '0;
   assign if_pc    = if_valid ? pcMem[rdPtr]    : '0;

   always_comb begin
      stateNext = state;
      fpcNext   = fpc;
      reqNext   = imem_req;
      addrNext  = imem_addr;
      countNext = count;
      rdPtrNext = rdPtr;
      wrPtrNext = wrPtr;
      push      = 1'b0;
      if (redirect_valid) begin
         fpcNext   = redirectTarget;
         countNext = '0;
         rdPtrNext = 1'b0;
         wrPtrNext = 1'b0;
         // An unacked request cannot be retracted: let it finish and discard its data.
         if (imem_req && !imem_ack) begin
            stateNext = DROP;
         end else begin
            stateNext = FETCH;
            reqNext   = 1'b1;
            addrNext  = redirectTarget;
         end
      end else begin
         if (pop) rdPtrNext = ~rdPtr;
         countNext = countPop;
         unique case (state)
            FETCH: begin
               if (ack) begin
                  push      = 1'b1;
                  wrPtrNext = ~wrPtr;
                  fpcNext   = fpc + 64'd4;
                  countNext = countPop + 2'd1;
                  if (countNext == DEPTH) begin
                     stateNext = STALL;
                     reqNext   = 1'b0;
                  end else begin
                     reqNext  = 1'b1;
                     addrNext = fpcNext;
                  end
               end else if (!imem_req && countPop < DEPTH) begin
                  reqNext  = 1'b1;
                  addrNext = fpc;
               end
            end
            STALL: begin
               if (pop) begin
                  stateNext = FETCH;
                  reqNext   = 1'b1;
                  addrNext  = fpc;
               end
            end
            DROP: begin
               if (ack) begin
                  stateNext = FETCH;
                  reqNext   = 1'b1;
                  addrNext  = fpc;
               end
            end
            default: stateNext = FETCH;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state     <= FETCH;
         fpc       <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         count     <= '0;
         rdPtr     <= 1'b0;
         wrPtr     <= 1'b0;
      end else begin
         state     <= stateNext;
         fpc       <= fpcNext;
         imem_req  <= reqNext;
         imem_addr <= addrNext;
         count     <= countNext;
         rdPtr     <= rdPtrNext;
         wrPtr     <= wrPtrNext;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         pcMem[wrPtr]    <= fpc;
         instrMem[wrPtr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit: a memory/redirect driver feeds a scoreboard
// of expected {pc, instr} entries; a monitor checks the decode side against it.
module tb_fetch_pc_unit;

   localparam logic [63:0] RPC = 64'h0;

   logic        CLK = 1'b0;
   logic        resetl;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [63:0] if_pc;
   logic        id_ready;

   fetch_pc_unit #(.RESET_PC(RPC), .BUF_DEPTH(2)) dut (
      .CLK(CLK), .resetl(resetl),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(id_ready)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } entryT;

   entryT       sb[$];
   int          checks = 0;
   int          errors = 0;
   bit          monEnable = 0;

   // model state
   logic [63:0] expAddr;
   logic [63:0] heldAddr;
   bit          outstanding, dropPending, pendPush, pendFlush, didMidReset;
   entryT       pendEntry;
   int          waitCnt, idle, readyPct;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clearModel();
      sb.delete();
      expAddr     = RPC;
      outstanding = 0;
      dropPending = 0;
      pendPush    = 0;
      pendFlush   = 0;
      waitCnt     = 0;
      idle        = 0;
   endtask

   task automatic checkResetOutputs(input string tag);
      check({tag, "_req"},   64'(imem_req), 64'd0);
      check({tag, "_addr"},  imem_addr, RPC);
      check({tag, "_valid"}, 64'(if_valid), 64'd0);
      check({tag, "_instr"}, 64'(if_instr), 64'd0);
      check({tag, "_pc"},    if_pc, 64'd0);
   endtask

   function automatic logic [63:0] pickTarget();
      logic [63:0] t;
      case ($urandom_range(0, 3))
         0:       t = {32'h0, $urandom};
         1:       t = {$urandom, $urandom};
         2:       t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
         default: t = 64'($urandom_range(0, 255));
      endcase
      return t;
   endfunction

   // Monitor: decode-side output must match the scoreboard head; pops on transfer.
   initial begin
      forever begin
         @(negedge CLK);
         #4;
         if (monEnable && resetl) begin
            check("ifValid", 64'(if_valid), 64'(sb.size() > 0));
            if (if_valid && sb.size() > 0) begin
               check("ifPc", if_pc, sb[0].pc);
               check("ifInstr", 64'(if_instr), 64'(sb[0].instr));
            end
            if (if_valid && id_ready && !redirect_valid && sb.size() > 0)
               void'(sb.pop_front());
         end
      end
   end

   // Driver: memory responder, redirect source and reference model.
   initial begin
      logic [63:0] tgt;
      resetl = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b0;
      didMidReset = 0;
      clearModel();
      repeat (2) @(negedge CLK);
      checkResetOutputs("reset");
      resetl    = 1'b1;
      monEnable = 1;

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge CLK);
         if (pendFlush) sb.delete();
         if (pendPush)  sb.push_back(pendEntry);
         pendFlush = 0;
         pendPush  = 0;

         if (!didMidReset && ((cyc > 2000 && dropPending) || cyc == 3000)) begin
            didMidReset    = 1;
            resetl         = 1'b0;
            imem_ack       = 1'b0;
            redirect_valid = 1'b0;
            id_ready       = 1'b0;
            #1;
            checkResetOutputs("midReset");
            repeat (2) @(negedge CLK);
            clearModel();
            resetl = 1'b1;
            continue;
         end

         // request-side checks against the model fetch PC
         if (imem_req) begin
            idle = 0;
            if (!outstanding) begin
               check("reqAddr", imem_addr, expAddr);
               check("reqSlots", 64'(sb.size() <= 1), 64'd1);
               outstanding = 1;
               heldAddr    = imem_addr;
            end else begin
               check("reqHold", imem_addr, heldAddr);
            end
         end else begin
            if (outstanding) begin
               check("reqRetract", 64'(imem_req), 64'd1);
               outstanding = 0;
            end
            if (sb.size() < 2) idle++;
            else idle = 0;
            if (idle == 3) begin
               check("reqLiveness", 64'(imem_req), 64'd1);
               idle = 0;
            end
         end

         // stimulus
         readyPct = (cyc < 150) ? 100 : (cyc < 500) ? 15 : 60;
         id_ready = ($urandom_range(0, 99) < readyPct);
         redirect_valid = (cyc > 20) && ($urandom_range(0, 99) < 6);
         tgt = pickTarget();
         redirect_pc = tgt;
         imem_ack = imem_req && (waitCnt >= 4 || $urandom_range(0, 99) < 40);
         imem_rdata = $urandom;

         // expected effect of the coming clock edge
         if (imem_ack) begin
            if (!redirect_valid && !dropPending) begin
               pendPush  = 1;
               pendEntry = '{pc: expAddr, instr: imem_rdata};
               expAddr   = expAddr + 64'd4;
            end
            outstanding = 0;
            dropPending = 0;
            waitCnt     = 0;
         end else if (imem_req) begin
            waitCnt++;
         end
         if (redirect_valid) begin
            pendFlush = 1;
            expAddr   = tgt - (tgt % 64'd4);
            if (imem_req && !imem_ack) dropPending = 1;
         end
      end

      @(negedge CLK);
      redirect_valid = 1'b0;
      imem_ack = 1'b0;
      monEnable = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
